apb_uart_master: RTL and testbench
==================================

Name: apb_uart_master

Overview:
- APB initiator that drives the UART APB slave core (UAPBCORE) from the system side.
- After reset it autonomously writes the baud and control registers.
- It then accepts single-beat read/write commands over a valid/ready interface, runs full APB SETUP/ACCESS phases, and returns read data or completion as a one-cycle response pulse.
- It sits between the host sequencer/CPU-side logic and the UART core.

Parameters:
- INIT_BAUD, 8'h0D, value written to address 2'b00 (baud divisor low) during init.
- INIT_CTRL, 8'h00, value written to address 2'b01 (control) during init.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait cycles. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  master accepts command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  2  register address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data (0 for writes).
- rsp_err  out  1  transfer aborted (timeout build only; else tied 0).
- init_done  out  1  init writes complete; sticky until reset.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  2  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready from slave.

Behaviour:
- Reset: on the first rising edge with PRESET=1, every output is 0 and the state is INIT_BAUD_S. Reset mid-transfer abandons the transfer with no rsp_valid, and the init sequence restarts after reset is released.
- States: INIT_BAUD_S, INIT_CTRL_S, IDLE, SETUP, ACCESS, RESP.
- INIT_BAUD_S: load a write of INIT_BAUD to 2'b00, then go to SETUP. The return-state tag is INIT_CTRL_S.
- INIT_CTRL_S: load a write of INIT_CTRL to 2'b01, then go to SETUP. The return-state tag is IDLE, and init_done is set on that transfer's completion.
- Init transfers never assert rsp_valid. cmd_ready stays 0 until init_done=1.
- IDLE: cmd_ready = init_done. When cmd_valid && cmd_ready, register addr/write/wdata and go to SETUP on the next edge.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. PADDR, PWRITE and PWDATA are valid and held constant until the transfer ends. PWDATA=0 for reads.
- ACCESS: PSEL=1, PENABLE=1; remain here while PREADY=0.
- ACCESS completion: on an edge with PREADY=1, capture PRDATA for reads (0 for writes). Next state is RESP for host commands, otherwise the tagged return state.
- RESP (1 cycle): PSEL=0, PENABLE=0, rsp_valid=1, rsp_rdata=captured value; then go to IDLE.
- Minimum host transfer: accept edge → SETUP → ACCESS → RESP, i.e. 4 cycles from accept to next cmd_ready.
- PREADY outside ACCESS is ignored.
- cmd_valid during a transfer is not accepted. The host must hold its fields until cmd_ready.
- PADDR/PWRITE/PWDATA keep their last values while PSEL=0. There are no glitches between SETUP and ACCESS.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An 8+ bit counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY still 0, drop PSEL/PENABLE next edge.
  - Host transfer: go to RESP with rsp_err=1, rsp_rdata=0.
  - Init transfer: retry the same init write from its INIT state.
- APB_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely.
  - rsp_err is constant 0, and there is no counter logic.

Decomposition:
- Package uart_apb_pkg holds:
  - state enum typedef apb_mst_state_t;
  - address constants UART_ADDR_BAUD_LO=2'b00, UART_ADDR_CTRL=2'b01, UART_ADDR_TXDATA=2'b10, UART_ADDR_STATUS=2'b11;
  - data width constant UART_DW=8.
- One natural sub-module: apb_timeout_cnt (counter plus expiry flag), instantiated only under APB_TIMEOUT_EN. Everything else stays flat.

Test Plan:
- Reset release, PREADY tied 1 → write 2'h0/8'h0D, then 2'h1/8'h00; each SETUP exactly 1 cycle; init_done=1 after the second ACCESS; no rsp_valid.
- Host write addr 2'b10 data 8'h9A, PREADY=1 → PSEL high 2 cycles, PWDATA=8'h9A stable; rsp_valid pulse 1 cycle, rsp_rdata=0.
- Host read addr 2'b11, slave inserts 3 wait states, PRDATA=8'h5C on the ready cycle → ACCESS lasts 4 cycles; rsp_rdata=8'h5C.
- Back-to-back commands with cmd_valid held → accepts spaced exactly 4 cycles; second command held off (cmd_ready=0) during the first.
- PRESET asserted during ACCESS of a host read → next edge all outputs 0, no rsp_valid; after release, init writes repeat.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 on a host read → PSEL falls after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB initiator.
// State encoding, UART register map and data width.
package uart_apb_pkg;

   localparam int UART_DW = 8;

   localparam logic [1:0] UART_ADDR_BAUD_LO = 2'b00;
   localparam logic [1:0] UART_ADDR_CTRL    = 2'b01;
   localparam logic [1:0] UART_ADDR_TXDATA  = 2'b10;
   localparam logic [1:0] UART_ADDR_STATUS  = 2'b11;

   typedef enum logic [2:0] {
      INIT_BAUD_S,
      INIT_CTRL_S,
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_mst_state_t;

endpackage

// File: rtl/apb_uart_master_if.sv
// Host command/response handshake plus APB bus bundle.
// master = initiator view, slave = host + APB target view.
interface apb_uart_master_if;
   import uart_apb_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_write;
   logic [1:0]         cmd_addr;
   logic [UART_DW-1:0] cmd_wdata;
   logic               rsp_valid;
   logic [UART_DW-1:0] rsp_rdata;
   logic               rsp_err;
   logic               init_done;
   logic               PSEL;
   logic               PENABLE;
   logic [1:0]         PADDR;
   logic               PWRITE;
   logic [UART_DW-1:0] PWDATA;
   logic [UART_DW-1:0] PRDATA;
   logic               PREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  PRDATA, PREADY,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output PRDATA, PREADY,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, init_done,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter with expiry flag.
// Only built when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES > 256) ?
                       $clog2(TIMEOUT_CYCLES) : 8;

   logic [CW-1:0] r_cnt;

   // clear at SETUP, count stalled ACCESS cycles
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expired = i_inc &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_uart_master.sv
// APB initiator for the UART core: init writes, then host commands.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase timeout.
module apb_uart_master
   import uart_apb_pkg::*;
#(
   parameter logic [UART_DW-1:0] INIT_BAUD      = 8'h0D,
   parameter logic [UART_DW-1:0] INIT_CTRL      = 8'h00,
   parameter int                 TIMEOUT_CYCLES = 256
) (
   input logic                PCLK,
   input logic                PRESET,
   apb_uart_master_if.master  bus
);

   apb_mst_state_t     r_state;
   apb_mst_state_t     w_next;
   apb_mst_state_t     r_ret;
   apb_mst_state_t     w_ret;
   logic [1:0]         r_addr;
   logic [1:0]         w_addr;
   logic               r_write;
   logic               w_wr;
   logic [UART_DW-1:0] r_wdata;
   logic [UART_DW-1:0] w_wdata;
   logic [UART_DW-1:0] r_rdata;
   logic               r_init_done;
   logic               w_load;
   logic               w_setup;
   logic               w_access;
   logic               w_rsp;
   logic               w_done;
   logic               w_expired;

   assign w_setup  = (r_state == SETUP);
   assign w_access = (r_state == ACCESS);
   assign w_rsp    = (r_state == RESP);
   assign w_done   = w_access && bus.PREADY;

`ifdef APB_TIMEOUT_EN
   logic r_err;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .i_clk     (PCLK),
      .i_rst     (PRESET),
      .i_clr     (w_setup),
      .i_inc     (w_access && !bus.PREADY),
      .o_expired (w_expired)
   );

   // abort flag reported with the response
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_err <= 1'b0;
      end else if (w_done) begin
         r_err <= 1'b0;
      end else if (w_expired) begin
         r_err <= 1'b1;
      end
   end

   assign bus.rsp_err = w_rsp && r_err;
`else
   logic w_unused_tmo;

   assign w_expired    = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign bus.rsp_err  = 1'b0;
`endif

   // next state and transfer-load decode
   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_addr  = r_addr;
      w_wr    = r_write;
      w_wdata = r_wdata;
      w_ret   = r_ret;
      unique case (r_state)
         INIT_BAUD_S: begin
            w_load  = 1'b1;
            w_addr  = UART_ADDR_BAUD_LO;
            w_wr    = 1'b1;
            w_wdata = INIT_BAUD;
            w_ret   = INIT_CTRL_S;
            w_next  = SETUP;
         end
         INIT_CTRL_S: begin
            w_load  = 1'b1;
            w_addr  = UART_ADDR_CTRL;
            w_wr    = 1'b1;
            w_wdata = INIT_CTRL;
            w_ret   = IDLE;
            w_next  = SETUP;
         end
         IDLE: begin
            if (bus.cmd_valid && r_init_done) begin
               w_load  = 1'b1;
               w_addr  = bus.cmd_addr;
               w_wr    = bus.cmd_write;
               w_wdata = bus.cmd_write ? bus.cmd_wdata : '0;
               w_ret   = RESP;
               w_next  = SETUP;
            end
         end
         SETUP: begin
            w_next = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               w_next = r_ret;
            end else if (w_expired) begin
               if (r_ret == RESP) begin
                  w_next = RESP;
               end else if (r_ret == INIT_CTRL_S) begin
                  w_next = INIT_BAUD_S;
               end else begin
                  w_next = INIT_CTRL_S;
               end
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = INIT_BAUD_S;
         end
      endcase
   end

   // state register
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= INIT_BAUD_S;
      end else begin
         r_state <= w_next;
      end
   end

   // transfer fields held for the whole APB transfer
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_ret   <= INIT_CTRL_S;
      end else if (w_load) begin
         r_addr  <= w_addr;
         r_write <= w_wr;
         r_wdata <= w_wdata;
         r_ret   <= w_ret;
      end
   end

   // read capture and sticky init completion
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_rdata     <= '0;
         r_init_done <= 1'b0;
      end else if (w_done) begin
         r_rdata <= r_write ? '0 : bus.PRDATA;
         if (r_ret == IDLE) begin
            r_init_done <= 1'b1;
         end
      end else if (w_expired) begin
         r_rdata <= '0;
      end
   end

   assign bus.PSEL      = w_setup || w_access;
   assign bus.PENABLE   = w_access;
   assign bus.PADDR     = r_addr;
   assign bus.PWRITE    = r_write;
   assign bus.PWDATA    = r_wdata;
   assign bus.rsp_valid = w_rsp;
   assign bus.rsp_rdata = w_rsp ? r_rdata : '0;
   assign bus.cmd_ready = (r_state == IDLE) && r_init_done;
   assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: directed table, corner sequences,
// randomized commands against a register-map reference model.
module tb_apb_uart_master;
   import uart_apb_pkg::*;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   apb_uart_master_if bus();

   apb_uart_master #(
      .INIT_BAUD      (8'h0D),
      .INIT_CTRL      (8'h00),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .PCLK   (clk),
      .PRESET (rst),
      .bus    (bus)
   );

   // ---------------- APB target model ----------------
   typedef struct {
      logic [1:0] a;
      logic       w;
      logic [7:0] d;
   } xfer_t;

   logic [7:0] s_mem [4];
   int         s_waits = 0;
   int         s_cnt = 0;
   bit         s_stuck = 1'b0;
   xfer_t      apb_log [$];

   assign bus.PREADY = !s_stuck && (s_cnt >= s_waits);
   assign bus.PRDATA = s_mem[bus.PADDR];

   always @(posedge clk) begin
      if (rst) begin
         s_cnt <= 0;
      end else if (bus.PSEL && bus.PENABLE) begin
         if (bus.PREADY) begin
            s_cnt <= 0;
            if (bus.PWRITE) s_mem[bus.PADDR] <= bus.PWDATA;
            apb_log.push_back('{bus.PADDR, bus.PWRITE, bus.PWDATA});
         end else begin
            s_cnt <= s_cnt + 1;
         end
      end
   end

   // ---------------- bus activity monitor ----------------
   int mon_setup = 0;
   int mon_access = 0;
   int mon_rsp = 0;

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.PSEL && !bus.PENABLE) mon_setup <= mon_setup + 1;
         if (bus.PSEL && bus.PENABLE) mon_access <= mon_access + 1;
         if (bus.rsp_valid) mon_rsp <= mon_rsp + 1;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] all_outs();
      return {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE,
              bus.PWDATA, bus.cmd_ready, bus.rsp_valid,
              bus.rsp_rdata, bus.rsp_err, bus.init_done};
   endfunction

   // reference register map as seen by the host
   logic [7:0] m_mem [4];

   task automatic model_init();
      m_mem[0] = 8'h0D;
      m_mem[1] = 8'h00;
   endtask

   // issue one command (called at a negedge), follow it to rsp_valid
   task automatic do_cmd(input logic w, input logic [1:0] a,
                         input logic [7:0] d,
                         output logic [7:0] rd, output logic er,
                         output int acc, output int st,
                         output bit ok, output bit stb);
      int n;
      logic [10:0] held;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      acc  = 0;
      st   = 0;
      ok   = 1'b0;
      stb  = 1'b1;
      rd   = 8'hxx;
      er   = 1'bx;
      held = '0;
      for (int i = 0; i < 400; i++) begin
         if (bus.rsp_valid) begin
            rd = bus.rsp_rdata;
            er = bus.rsp_err;
            ok = 1'b1;
            break;
         end
         if (bus.PSEL && !bus.PENABLE) begin
            st++;
            held = {bus.PADDR, bus.PWRITE, bus.PWDATA};
         end
         if (bus.PSEL && bus.PENABLE) begin
            acc++;
            if (held !== {bus.PADDR, bus.PWRITE, bus.PWDATA}) stb = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic chk_log1(input string tag, input logic w,
                           input logic [1:0] a, input logic [7:0] d);
      chk({tag, "_logn"}, apb_log.size(), 1);
      if (apb_log.size() > 0) begin
         chk({tag, "_log"},
             {apb_log[0].a, apb_log[0].w, apb_log[0].d},
             {a, w, (w ? d : 8'h00)});
      end
   endtask

   task automatic run_rand(input logic w, input logic [1:0] a,
                           input logic [7:0] d, input int waits);
      logic [7:0] rd;
      logic [7:0] exp;
      logic       er;
      int         acc;
      int         st;
      bit         ok;
      bit         stb;
      s_waits = waits;
      apb_log.delete();
      exp = w ? 8'h00 : m_mem[a];
      do_cmd(w, a, d, rd, er, acc, st, ok, stb);
      if (w) m_mem[a] = d;
      chk("rnd_done", ok, 1);
      chk("rnd_rdata", rd, exp);
      chk("rnd_err", er, 0);
      chk("rnd_access", acc, waits + 1);
      chk("rnd_setup", st, 1);
      chk("rnd_stable", stb, 1);
      chk_log1("rnd", w, a, d);
      @(negedge clk);
      chk("rnd_pulse", bus.rsp_valid, 0);
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (!bus.init_done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, bus.init_done, 1);
      chk({tag, "_setups"}, mon_setup, 2);
      chk({tag, "_access"}, mon_access, 2);
      chk({tag, "_norsp"}, mon_rsp, 0);
      chk({tag, "_logn"}, apb_log.size(), 2);
      if (apb_log.size() == 2) begin
         chk({tag, "_baud"},
             {apb_log[0].a, apb_log[0].w, apb_log[0].d},
             {2'b00, 1'b1, 8'h0D});
         chk({tag, "_ctrl"},
             {apb_log[1].a, apb_log[1].w, apb_log[1].d},
             {2'b01, 1'b1, 8'h00});
      end
   endtask

   typedef struct {
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      int         waits;
      logic [7:0] exp_rd;
      int         exp_acc;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [7:0] rd;
      logic       er;
      int         acc;
      int         st;
      bit         ok;
      bit         stb;
      int         first;
      int         second;
      bit         swap;

      tbl[0] = '{1'b1, 2'b10, 8'h9A, 0, 8'h00, 1};
      tbl[1] = '{1'b0, 2'b11, 8'h00, 3, 8'h5C, 4};
      tbl[2] = '{1'b0, 2'b00, 8'h00, 0, 8'h0D, 1};
      tbl[3] = '{1'b0, 2'b01, 8'h00, 1, 8'h00, 2};
      tbl[4] = '{1'b1, 2'b01, 8'hA5, 2, 8'h00, 3};
      tbl[5] = '{1'b0, 2'b01, 8'h00, 0, 8'hA5, 1};
      tbl[6] = '{1'b0, 2'b10, 8'h00, 2, 8'h9A, 3};

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 2'b00;
      bus.cmd_wdata = 8'h00;
      for (int i = 0; i < 4; i++) begin
         s_mem[i] = 8'h00;
         m_mem[i] = 8'h00;
      end
      model_init();

      // reset state
      rst = 1'b1;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b0;
      mon_setup  = 0;
      mon_access = 0;
      mon_rsp    = 0;
      apb_log.delete();

      // autonomous init with PREADY tied high
      wait_init("init");

      // directed table
      s_mem[3] = 8'h5C;
      m_mem[3] = 8'h5C;
      for (int i = 0; i < 7; i++) begin
         s_waits = tbl[i].waits;
         apb_log.delete();
         do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, rd, er, acc, st, ok, stb);
         if (tbl[i].w) m_mem[tbl[i].a] = tbl[i].d;
         chk($sformatf("tbl%0d_done", i), ok, 1);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_err", i), er, 0);
         chk($sformatf("tbl%0d_access", i), acc, tbl[i].exp_acc);
         chk($sformatf("tbl%0d_setup", i), st, 1);
         chk($sformatf("tbl%0d_stable", i), stb, 1);
         chk_log1($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d);
         @(negedge clk);
         chk($sformatf("tbl%0d_pulse", i), bus.rsp_valid, 0);
      end

      // back-to-back commands with cmd_valid held
      s_waits = 0;
      mon_rsp = 0;
      apb_log.delete();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 2'b10;
      bus.cmd_wdata = 8'h11;
      first  = -1;
      second = -1;
      swap   = 1'b0;
      for (int c = 0; c < 40 && second < 0; c++) begin
         if (swap) begin
            bus.cmd_addr  = 2'b11;
            bus.cmd_wdata = 8'h22;
            swap = 1'b0;
         end
         if (bus.cmd_ready) begin
            if (first < 0) begin
               first = c;
               swap  = 1'b1;
            end else begin
               second = c;
            end
         end
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      m_mem[2] = 8'h11;
      m_mem[3] = 8'h22;
      chk("b2b_second_seen", (second >= 0), 1);
      chk("b2b_spacing", second - first, 4);
      for (int c = 0; c < 20 && mon_rsp < 2; c++) @(negedge clk);
      chk("b2b_rsp_count", mon_rsp, 2);
      chk("b2b_logn", apb_log.size(), 2);
      if (apb_log.size() == 2) begin
         chk("b2b_first", {apb_log[0].a, apb_log[0].d}, {2'b10, 8'h11});
         chk("b2b_second", {apb_log[1].a, apb_log[1].d}, {2'b11, 8'h22});
      end
      @(negedge clk);

      // randomized commands against the reference map
      for (int i = 0; i < 30; i++) begin
         run_rand(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end

      // reset during ACCESS of a host read
      s_waits = 5;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 2'b11;
      for (int c = 0; c < 20 && !bus.cmd_ready; c++) @(negedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b0;
      s_waits    = 0;
      mon_setup  = 0;
      mon_access = 0;
      mon_rsp    = 0;
      apb_log.delete();
      model_init();
      wait_init("reinit");
      @(negedge clk);
      run_rand(1'b0, 2'b00, 8'h00, 0);
      run_rand(1'b0, 2'b11, 8'h00, 1);

`ifdef APB_TIMEOUT_EN
      // stuck slave: abort after TMO ACCESS cycles
      s_stuck = 1'b1;
      apb_log.delete();
      do_cmd(1'b0, 2'b01, 8'h00, rd, er, acc, st, ok, stb);
      chk("tmo_done", ok, 1);
      chk("tmo_err", er, 1);
      chk("tmo_rdata", rd, 0);
      chk("tmo_access", acc, TMO);
      chk("tmo_setup", st, 1);
      chk("tmo_nolog", apb_log.size(), 0);
      s_stuck = 1'b0;
      @(negedge clk);
      run_rand(1'b0, 2'b01, 8'h00, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
